// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory responder.
// Holds the FSM state enum, default register addresses and the RAM region mask.
package data_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  localparam logic [31:0] LED_ADDR_DEF = 32'h0000_FF00;
  localparam logic [31:0] CNT_ADDR_DEF = 32'h0000_FF04;

  // An address is a RAM word access when every masked bit is zero.
  localparam logic [31:0] RAM_REGION_MASK = 32'hFFFF_F003;

  // Byte-lane merge of new data into an existing word.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_d,
                                                    input logic [DATA_W-1:0] new_d,
                                                    input logic [LANES-1:0]  lane_en);
    logic [DATA_W-1:0] res;
    res = old_d;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane_en[i]) res[8*i +: 8] = new_d[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_responder_ram_bytelane.sv
// Word-organised RAM with per-byte write enables.
// Synchronous write, asynchronous read; contents are never reset.
module ram_bytelane
  import data_mem_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic              clk,
  input  logic [LANES-1:0]  we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-initiator memory responder: RAM, LED register and cycle counter
// behind a req/ready handshake with a configurable number of wait states.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RAM_WORDS   = 1024,
  parameter logic [31:0] LED_ADDR    = LED_ADDR_DEF,
  parameter logic [31:0] CNT_ADDR    = CNT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        CPU_RESETN,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] led_data
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  state_t              state;
  state_t              next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   next_wait_cnt;
  logic [31:0]         cycle_cnt;
  logic [DATA_W-1:0]   ram_rdata;
  logic [LANES-1:0]    ram_we;
  logic                hit_ram;
  logic                hit_led;
  logic                acc_err;
  logic [DATA_W-1:0]   acc_rdata;
  logic                commit;

  // State register
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait_cnt;
    end
  end

  // Next-state logic
  always_comb begin
    next_state    = state;
    next_wait_cnt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            next_state = ST_RESP;
          end else begin
            next_state    = ST_WAIT;
            next_wait_cnt = WAIT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          next_state    = ST_IDLE;
          next_wait_cnt = '0;
        end else if (wait_cnt == '0) begin
          next_state = ST_RESP;
        end else begin
          next_wait_cnt = wait_cnt - WAIT_W'(1);
        end
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Address decode; fields are only meaningful while in RESP
  always_comb begin
    hit_ram   = 1'b0;
    hit_led   = 1'b0;
    acc_err   = 1'b1;
    acc_rdata = '0;
    if (addr[1:0] != 2'b00) begin
      acc_err = 1'b1;
    end else if ((addr & RAM_REGION_MASK) == 32'h0) begin
      hit_ram   = 1'b1;
      acc_err   = 1'b0;
      acc_rdata = wr ? '0 : ram_rdata;
    end else if (addr == LED_ADDR) begin
      hit_led   = 1'b1;
      acc_err   = 1'b0;
      acc_rdata = wr ? '0 : led_data;
    end else if (addr == CNT_ADDR && !wr) begin
      acc_err   = 1'b0;
      acc_rdata = cycle_cnt;
    end
  end

  // Output logic
  always_comb begin
    ready = 1'b0;
    rdata = '0;
    err   = 1'b0;
    if (state == ST_RESP) begin
      ready = 1'b1;
      rdata = acc_rdata;
      err   = acc_err;
    end
  end

  assign commit = (state == ST_RESP) && wr && !acc_err;
  assign ram_we = (commit && hit_ram) ? sel : '0;

  ram_bytelane #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr[AW+1:2]),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  // LED register, written with byte-lane merge when the write response retires
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      led_data <= '0;
    end else if (commit && hit_led) begin
      led_data <= merge_lanes(led_data, wdata, sel);
    end
  end

  // Free-running cycle counter
  always_ff @(posedge clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed vector table, corner sequences
// and randomized traffic against a behavioural memory-map model.
module tb_data_mem_responder;

  localparam logic [31:0] LED_A = 32'h0000_FF00;
  localparam logic [31:0] CNT_A = 32'h0000_FF04;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr    = 1'b0;
  logic [3:0]  sel   = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        req0  = 1'b0;
  logic        req1  = 1'b0;
  logic        req3  = 1'b0;

  logic        rdy0, rdy1, rdy3;
  logic        err0, err1, err3;
  logic [31:0] rd0, rd1, rd3;
  logic [31:0] led0, led1, led3;

  data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .CPU_RESETN(rst_n), .req(req0), .wr(wr), .sel(sel), .addr(addr),
    .wdata(wdata), .ready(rdy0), .rdata(rd0), .err(err0), .led_data(led0));

  data_mem_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .CPU_RESETN(rst_n), .req(req1), .wr(wr), .sel(sel), .addr(addr),
    .wdata(wdata), .ready(rdy1), .rdata(rd1), .err(err1), .led_data(led1));

  data_mem_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .CPU_RESETN(rst_n), .req(req3), .wr(wr), .sel(sel), .addr(addr),
    .wdata(wdata), .ready(rdy3), .rdata(rd3), .err(err3), .led_data(led3));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference cycle count: clock edges seen since reset release
  logic [31:0] cyc = 32'h0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 32'h0;
    else        cyc <= cyc + 32'd1;
  end

  logic [31:0] mem_m [16];
  logic [31:0] led_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic get_rdy(input int which);
    return (which == 0) ? rdy0 : (which == 1) ? rdy1 : rdy3;
  endfunction

  function automatic logic get_err(input int which);
    return (which == 0) ? err0 : (which == 1) ? err1 : err3;
  endfunction

  function automatic logic [31:0] get_rd(input int which);
    return (which == 0) ? rd0 : (which == 1) ? rd1 : rd3;
  endfunction

  task automatic set_req(input int which, input logic v);
    case (which)
      0:       req0 = v;
      1:       req1 = v;
      default: req3 = v;
    endcase
  endtask

  // One complete handshake; lat counts clock edges until ready is seen
  task automatic txn(input int which, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat,
                     output logic [31:0] cnt_at);
    logic got;
    @(negedge clk);
    wr = w; sel = s; addr = a; wdata = d;
    set_req(which, 1'b1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (get_rdy(which)) got = 1'b1;
    end
    if (!got) check("ready_timeout", 32'(got), 32'd1);
    rd     = get_rd(which);
    e      = get_err(which);
    cnt_at = cyc;
    set_req(which, 1'b0);
  endtask

  typedef struct {
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, cnt_at, prev, a, d, exp_rd;
    logic        e, w, exp_err, seen, have_prev;
    logic [3:0]  s;
    int          lat, kind, idx;

    tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 32'h0000_0020, 32'hAABB_CCDD, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 4'hC, 32'h0000_0020, 32'h1122_3344, 32'h0,         1'b0};
    tbl[4]  = '{1'b0, 4'h3, 32'h0000_0020, 32'h0,         32'h1122_CCDD, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 32'h0000_0022, 32'h0,         32'h0,         1'b1};
    tbl[6]  = '{1'b1, 4'hF, CNT_A,         32'h5555_5555, 32'h0,         1'b1};
    tbl[7]  = '{1'b0, 4'hF, 32'h0001_0000, 32'h0,         32'h0,         1'b1};
    tbl[8]  = '{1'b1, 4'hF, 32'h0000_0022, 32'h0BAD_0BAD, 32'h0,         1'b1};
    tbl[9]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h1122_CCDD, 1'b0};
    tbl[10] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         32'h0,         1'b0};
    tbl[11] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{1'b1, 4'hF, LED_A,         32'h1234_5678, 32'h0,         1'b0};
    tbl[13] = '{1'b0, 4'hF, LED_A,         32'h0,         32'h1234_5678, 1'b0};
    tbl[14] = '{1'b1, 4'h8, LED_A,         32'hAB00_0000, 32'h0,         1'b0};
    tbl[15] = '{1'b0, 4'hF, LED_A,         32'h0,         32'hAB34_5678, 1'b0};
    tbl[16] = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0,         1'b1};
    tbl[17] = '{1'b0, 4'hF, 32'h0000_F000, 32'h0,         32'h0,         1'b1};

    // Asynchronous reset: outputs clear with no clock edge
    #1 rst_n = 1'b0;
    #1;
    check("reset_ready", 32'(rdy1), 32'd0);
    check("reset_rdata", rd1, 32'h0);
    check("reset_err",   32'(err1), 32'd0);
    check("reset_led",   led1, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    foreach (tbl[i]) begin
      txn(1, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, rd, e, lat, cnt_at);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      if (!tbl[i].w || tbl[i].exp_err) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
    end

    // LED updates on the edge that ends the ready cycle
    txn(1, 1'b1, 4'hF, LED_A, 32'hCAFE_F00D, rd, e, lat, cnt_at);
    check("led_at_ready", led1, 32'hAB34_5678);
    @(negedge clk);
    check("led_after_ready", led1, 32'hCAFE_F00D);
    check("idle_rdata", rd1, 32'h0);
    check("idle_err", 32'(err1), 32'd0);

    // Asynchronous reset mid-cycle clears LEDs; RAM keeps its contents
    #2 rst_n = 1'b0;
    #1;
    check("areset_led1", led1, 32'h0);
    check("areset_led0", led0, 32'h0);
    check("areset_led3", led3, 32'h0);
    #1 rst_n = 1'b1;
    txn(1, 1'b0, 4'hF, 32'h0000_0010, 32'h0, rd, e, lat, cnt_at);
    check("retain_0x10", rd, 32'hDEAD_BEEF);
    txn(1, 1'b0, 4'hF, 32'h0000_0020, 32'h0, rd, e, lat, cnt_at);
    check("retain_0x20", rd, 32'h1122_CCDD);

    // Three wait states: latency and abort
    txn(3, 1'b1, 4'hF, 32'h0000_0030, 32'h5555_5555, rd, e, lat, cnt_at);
    check("w3_lat", 32'(lat), 32'd4);
    check("w3_err", 32'(e), 32'd0);
    @(negedge clk);
    wr = 1'b1; sel = 4'hF; addr = 32'h0000_0030; wdata = 32'h7777_7777; req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rdy3) seen = 1'b1;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    txn(3, 1'b0, 4'hF, 32'h0000_0030, 32'h0, rd, e, lat, cnt_at);
    check("abort_lat", 32'(lat), 32'd4);
    check("abort_ram", rd, 32'h5555_5555);

    // Reset during WAIT drops the pending write
    @(negedge clk);
    wr = 1'b1; sel = 4'hF; addr = 32'h0000_0030; wdata = 32'h6666_6666; req3 = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_ready", 32'(rdy3), 32'd0);
    req3 = 1'b0;
    #1 rst_n = 1'b1;
    txn(3, 1'b0, 4'hF, 32'h0000_0030, 32'h0, rd, e, lat, cnt_at);
    check("rst_wait_ram", rd, 32'h5555_5555);

    // Zero wait states, request held: ready every second cycle
    @(negedge clk);
    wr = 1'b0; sel = 4'hF; addr = CNT_A; req0 = 1'b1;
    have_prev = 1'b0;
    prev = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ready%0d", i), 32'(rdy0), 32'(i % 2));
      if (rdy0) begin
        check($sformatf("b2b_cnt%0d", i), rd0, cyc);
        if (have_prev) check($sformatf("b2b_delta%0d", i), rd0 - prev, 32'd2);
        prev = rd0;
        have_prev = 1'b1;
      end else begin
        check($sformatf("b2b_idle_rdata%0d", i), rd0, 32'h0);
      end
    end
    req0 = 1'b0;

    // Randomized traffic against the memory-map model
    led_m = 32'h0;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      txn(1, 1'b1, 4'hF, 32'(i * 4), d, rd, e, lat, cnt_at);
      check($sformatf("init%0d_err", i), 32'(e), 32'd0);
      mem_m[i] = d;
    end
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 15);
      w    = 1'($urandom_range(0, 1));
      s    = 4'($urandom);
      d    = $urandom;
      case (kind)
        6:       a = LED_A;
        7:       a = CNT_A;
        8:       a = 32'(idx * 4 + $urandom_range(1, 3));
        9:       a = $urandom | 32'h0001_0000;
        default: a = 32'(idx * 4);
      endcase
      txn(1, w, s, a, d, rd, e, lat, cnt_at);
      exp_err = 1'b1;
      exp_rd  = 32'h0;
      if (a % 4 != 0) begin
        exp_err = 1'b1;
      end else if (a < 32'h1000) begin
        exp_err = 1'b0;
        if (w) mem_m[a / 4] = merge(mem_m[a / 4], d, s);
        else   exp_rd = mem_m[a / 4];
      end else if (a == LED_A) begin
        exp_err = 1'b0;
        if (!w) exp_rd = led_m;
      end else if (a == CNT_A && !w) begin
        exp_err = 1'b0;
        exp_rd  = cnt_at;
      end
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("rnd%0d_err", i), 32'(e), 32'(exp_err));
      if (!w || exp_err) check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      if (w && a == LED_A) led_m = merge(led_m, d, s);
      @(negedge clk);
      check($sformatf("rnd%0d_led", i), led1, led_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, meaning number of wait states inserted before each response (legal 0..15).
REQ-002 Parameter RAM_WORDS, default 1024, meaning depth of the 32-bit data RAM.
REQ-003 Parameter LED_ADDR, default 32'h0000_FF00, meaning byte address of the LED data register.
REQ-004 Parameter CNT_ADDR, default 32'h0000_FF04, meaning byte address of the read-only cycle counter.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 CPU_RESETN  input  1  reset, asynchronous, active-low.
REQ-007 req  input  1  initiator request; held high with addr/wr/sel/wdata stable until ready.
REQ-008 wr  input  1  1 = write, 0 = read.
REQ-009 sel  input  4  byte-lane enables for writes; bit i covers wdata[8i+7:8i].
REQ-010 addr  input  32  byte address.
REQ-011 wdata  input  32  write data.
REQ-012 ready  output  1  one-cycle response strobe.
REQ-013 rdata  output  32  read data, valid only while ready=1, else 0.
REQ-014 err  output  1  error flag, valid only while ready=1, else 0.
REQ-015 led_data  output  32  current LED register contents.

Function
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 IDLE: req=1 and WAIT_CYCLES>0 -> WAIT with wait counter loaded to WAIT_CYCLES-1; req=1 and WAIT_CYCLES=0 -> RESP; else stay.
REQ-018 WAIT: req=0 -> IDLE (abort, no side effect); counter=0 -> RESP; else decrement.
REQ-019 RESP: ready=1 for exactly one cycle, then unconditionally IDLE; back-to-back requests therefore have one idle cycle between ready pulses.
REQ-020 Latency: ready asserts WAIT_CYCLES+1 cycles after the cycle req is first sampled high in IDLE.
REQ-021 RAM region: addr[31:12]==0 and addr[1:0]==0; word index addr[11:2].
REQ-022 RAM write: committed on the clock edge ending RESP, only the lanes with sel bit set; sel=4'b0000 writes nothing, err=0.
REQ-023 RAM read: rdata is the full 32-bit word regardless of sel.
REQ-024 LED_ADDR write: byte-lane merge into LED register at RESP edge; read returns LED register.
REQ-025 CNT_ADDR read: returns free-running 32-bit cycle counter sampled in RESP; counter increments every cycle, wraps 32'hFFFF_FFFF -> 0; write to CNT_ADDR: no effect, err=1.
REQ-026 addr[1:0]!=0 on any access: err=1, rdata=0, no state change.
REQ-027 Any other unmapped address: err=1, rdata=0, no state change.
REQ-028 Request fields are sampled in RESP, not at IDLE entry; initiator changes during WAIT are a protocol violation, behaviour undefined.

Reset
REQ-029 CPU_RESETN low: state=IDLE, wait counter=0, cycle counter=0, led_data=0, ready=0, rdata=0, err=0, immediately and without clock.
REQ-030 Reset mid-WAIT or mid-RESP: pending access dropped, no write committed.
REQ-031 RAM contents are not reset; they retain values across reset.

Structure
REQ-032 Shared package data_mem_pkg holds the state enum, default LED_ADDR/CNT_ADDR constants and the RAM-region mask.
REQ-033 One sub-module ram_bytelane: synchronous-write, asynchronous-read RAM with 4-bit byte write enable.
REQ-034 FSM, address decode, LED register and cycle counter live in data_mem_responder.

Verification
REQ-035 WAIT_CYCLES=1: write addr=0x10, wdata=0xDEADBEEF, sel=4'hF; read addr=0x10 -> ready on 2nd cycle after req, rdata=0xDEADBEEF, err=0.
REQ-036 Byte lanes: write 0x11223344 sel=4'b1100 over word 0xAABBCCDD at addr 0x20 -> read returns 0x1122CCDD.
REQ-037 Errors: read addr=0x22 -> err=1, rdata=0; write CNT_ADDR -> err=1; read addr=0x0001_0000 -> err=1; RAM unchanged.
REQ-038 LED: write LED_ADDR 0x12345678 sel=4'hF -> led_data=0x12345678 one cycle after ready; reset -> led_data=0 asynchronously.
REQ-039 Abort: WAIT_CYCLES=3, write req dropped after 1 cycle -> no ready, RAM word unchanged, FSM back in IDLE.
REQ-040 WAIT_CYCLES=0 back-to-back reads -> ready every 2nd cycle; CNT_ADDR read values differ by 2.
